// File: rtl/menu_navigator.sv
// menu_navigator: push-button key events driving a
// two-level location/activity menu with wrap, back and timeout.
module menu_navigator #(
  parameter int NUM_LOCS       = 2,
  parameter int NUM_ACTS       = 2,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] keys,
  input  logic       act_done,
  output logic [3:0] location,
  output logic [3:0] activity,
  output logic [3:0] cursor,
  output logic       act_start,
  output logic [1:0] state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [3:0] NL = 4'(NUM_LOCS);
  localparam logic [3:0] NA = 4'(NUM_ACTS);

  typedef enum logic [1:0] {
    ROOT   = 2'd0,
    MENU   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    keys_prev;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          abort_q, abort_d;
  logic [3:0]    loc_d, act_d, cur_d;
  logic          start_d;
  logic          idle, sel_only;
  logic          left_ev, right_ev, sel_ev, back_ev;
  logic          nav_ev, tmo_hit;

  function automatic logic [3:0] dec_wrap(
    input logic [3:0] c,
    input logic [3:0] n
  );
    return (c <= 4'd1) ? n : c - 4'd1;
  endfunction

  function automatic logic [3:0] inc_wrap(
    input logic [3:0] c,
    input logic [3:0] n
  );
    return (c >= n) ? 4'd1 : c + 4'd1;
  endfunction

  assign state = state_q;

  // Key event decode; a select hold only counts once it
  // starts from an idle sample, so keys held through
  // reset never produce select or back.
  always_comb begin
    idle     = (keys == 3'b000);
    sel_only = (keys == 3'b010);
    left_ev  = (keys_prev == 3'b000) && (keys == 3'b100);
    right_ev = (keys_prev == 3'b000) && (keys == 3'b001);
    back_ev  = sel_only && (hold_cnt == HOLD_MAX - 1'b1);
    sel_ev   = idle && (keys_prev == 3'b010) &&
               (hold_cnt != '0) && (hold_cnt < HOLD_MAX) &&
               !abort_q;
    nav_ev   = left_ev | right_ev | sel_ev;
    hold_d   = '0;
    if (sel_only &&
        ((hold_cnt != '0) || (keys_prev == 3'b000))) begin
      hold_d = (hold_cnt == HOLD_MAX) ?
        hold_cnt : hold_cnt + 1'b1;
    end
    abort_d = abort_q;
    if (idle) begin
      abort_d = 1'b0;
    end else if (!sel_only && (hold_cnt != '0)) begin
      abort_d = 1'b1;
    end
    tmo_hit = TMO_EN && !nav_ev && (tmo_cnt == TMO_LAST);
  end

  // Menu next-state and output-register updates.
  always_comb begin
    state_d = state_q;
    loc_d   = location;
    act_d   = activity;
    cur_d   = cursor;
    start_d = 1'b0;
    tmo_d   = '0;
    unique case (state_q)
      ROOT: begin
        if (left_ev) begin
          cur_d = dec_wrap(cursor, NL);
        end else if (right_ev) begin
          cur_d = inc_wrap(cursor, NL);
        end else if (sel_ev) begin
          loc_d   = cursor;
          cur_d   = 4'd1;
          state_d = MENU;
        end
      end
      MENU: begin
        if (left_ev) begin
          cur_d = dec_wrap(cursor, NA);
        end else if (right_ev) begin
          cur_d = inc_wrap(cursor, NA);
        end else if (sel_ev) begin
          act_d   = cursor;
          start_d = 1'b1;
          state_d = ACTIVE;
        end else if (back_ev) begin
          cur_d   = location;
          loc_d   = 4'd0;
          state_d = ROOT;
        end
      end
      ACTIVE: begin
        if (act_done || back_ev || tmo_hit) begin
          cur_d   = activity;
          act_d   = 4'd0;
          state_d = MENU;
        end else if (TMO_EN && !nav_ev) begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      default: begin
        loc_d   = 4'd0;
        act_d   = 4'd0;
        cur_d   = 4'd1;
        state_d = ROOT;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ROOT;
      location  <= 4'd0;
      activity  <= 4'd0;
      cursor    <= 4'd1;
      act_start <= 1'b0;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      abort_q   <= 1'b0;
      keys_prev <= 3'b111;
    end else begin
      state_q   <= state_d;
      location  <= loc_d;
      activity  <= act_d;
      cursor    <= cur_d;
      act_start <= start_d;
      hold_cnt  <= hold_d;
      tmo_cnt   <= tmo_d;
      abort_q   <= abort_d;
      keys_prev <= keys;
    end
  end

endmodule

// File: tb/tb_menu_navigator.sv
// tb_menu_navigator: scoreboard bench for menu_navigator
// with 3 locations, 2 activities, hold 4, timeout 10.
module tb_menu_navigator;

  logic       clk;
  logic       resetn;
  logic [2:0] keys;
  logic       act_done;
  logic [3:0] location;
  logic [3:0] activity;
  logic [3:0] cursor;
  logic       act_start;
  logic [1:0] state;
  logic [14:0] obs;
  logic [14:0] exp_q [$];
  int n_chk;
  int n_pass;

  menu_navigator #(
    .NUM_LOCS(3),
    .NUM_ACTS(2),
    .HOLD_CYCLES(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .keys(keys),
    .act_done(act_done),
    .location(location),
    .activity(activity),
    .cursor(cursor),
    .act_start(act_start),
    .state(state)
  );

  assign obs = {state, location, activity, cursor, act_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ov(
    input int s, input int l, input int a,
    input int c, input int st
  );
    return {s[1:0], l[3:0], a[3:0], c[3:0], st[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    logic [2:0]  kv [4];
    resetn = 1'b0;
    keys = 3'b010;
    act_done = 1'b0;
    repeat (2) tick();
    exp_q.push_back(ov(0, 0, 0, 1, 0));
    e = exp_q.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL reset_state got %h want %h", obs, e);
    else n_pass++;
    resetn = 1'b1;
    kv = '{3'b010, 3'b010, 3'b000, 3'b000};
    for (int i = 0; i < 4; i++) begin
      keys = kv[i];
      exp_q.push_back(ov(0, 0, 0, 1, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL held_reset[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_root_nav();
    logic [14:0] e;
    logic [2:0]  kv [6];
    int          cv [6];
    kv = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
    cv = '{3, 3, 1, 1, 2, 2};
    for (int i = 0; i < 6; i++) begin
      keys = kv[i];
      exp_q.push_back(ov(0, 0, 0, cv[i], 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL root_nav[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_short_select();
    logic [14:0] e;
    logic [2:0]  kv [3];
    logic [14:0] ev [3];
    kv = '{3'b010, 3'b010, 3'b000};
    ev = '{ov(0, 0, 0, 2, 0), ov(0, 0, 0, 2, 0),
           ov(1, 2, 0, 1, 0)};
    for (int i = 0; i < 3; i++) begin
      keys = kv[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL short_select[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_enter_active();
    logic [14:0] e;
    logic [2:0]  kv [4];
    logic [14:0] ev [4];
    kv = '{3'b010, 3'b010, 3'b000, 3'b000};
    ev = '{ov(1, 2, 0, 1, 0), ov(1, 2, 0, 1, 0),
           ov(2, 2, 1, 1, 1), ov(2, 2, 1, 1, 0)};
    for (int i = 0; i < 4; i++) begin
      keys = kv[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL enter_active[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_act_done();
    logic [14:0] e;
    logic        av [4];
    av = '{1'b1, 1'b0, 1'b1, 1'b0};
    keys = 3'b000;
    for (int i = 0; i < 4; i++) begin
      act_done = av[i];
      exp_q.push_back(ov(1, 2, 0, 1, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL act_done[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
    act_done = 1'b0;
  endtask

  task automatic test_long_hold();
    logic [14:0] e;
    for (int i = 0; i < 8; i++) begin
      keys = (i < 6) ? 3'b010 : 3'b000;
      exp_q.push_back((i < 3) ? ov(1, 2, 0, 1, 0)
                              : ov(0, 0, 0, 2, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL long_hold[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_chord_abort();
    logic [14:0] e;
    logic [2:0]  kv [7];
    kv = '{3'b010, 3'b010, 3'b011, 3'b000,
           3'b000, 3'b101, 3'b000};
    for (int i = 0; i < 7; i++) begin
      keys = kv[i];
      exp_q.push_back(ov(0, 0, 0, 2, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL chord_abort[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [14:0] e;
    logic [2:0]  kv [8];
    logic [14:0] ev [8];
    kv = '{3'b010, 3'b010, 3'b000, 3'b001,
           3'b000, 3'b010, 3'b010, 3'b000};
    ev = '{ov(0, 0, 0, 2, 0), ov(0, 0, 0, 2, 0),
           ov(1, 2, 0, 1, 0), ov(1, 2, 0, 2, 0),
           ov(1, 2, 0, 2, 0), ov(1, 2, 0, 2, 0),
           ov(1, 2, 0, 2, 0), ov(2, 2, 2, 2, 1)};
    for (int i = 0; i < 8; i++) begin
      keys = kv[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL tmo_setup[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
    keys = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back((i < 10) ? ov(2, 2, 2, 2, 0)
                               : ov(1, 2, 0, 2, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL timeout[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_timeout_restart();
    logic [14:0] e;
    logic [2:0]  kv [3];
    logic [14:0] ev [3];
    kv = '{3'b010, 3'b010, 3'b000};
    ev = '{ov(1, 2, 0, 2, 0), ov(1, 2, 0, 2, 0),
           ov(2, 2, 2, 2, 1)};
    for (int i = 0; i < 3; i++) begin
      keys = kv[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL restart_setup[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
    for (int i = 1; i <= 17; i++) begin
      keys = (i == 7) ? 3'b001 : 3'b000;
      exp_q.push_back((i < 17) ? ov(2, 2, 2, 2, 0)
                               : ov(1, 2, 0, 2, 0));
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL tmo_restart[%0d] got %h want %h",
                 i, obs, e);
      else n_pass++;
    end
    keys = 3'b000;
  endtask

  task automatic test_async_reset();
    logic [14:0] e;
    tick();
    #3;
    resetn = 1'b0;
    exp_q.push_back(ov(0, 0, 0, 1, 0));
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL async_reset got %h want %h", obs, e);
    else n_pass++;
    exp_q.push_back(ov(0, 0, 0, 1, 0));
    tick();
    e = exp_q.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL reset_hold got %h want %h", obs, e);
    else n_pass++;
    resetn = 1'b1;
    exp_q.push_back(ov(0, 0, 0, 1, 0));
    tick();
    e = exp_q.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL reset_release got %h want %h", obs, e);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_root_nav();
    test_short_select();
    test_enter_active();
    test_act_done();
    test_long_hold();
    test_chord_abort();
    test_timeout();
    test_timeout_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/menu_navigator.md
# menu_navigator

Parametrised menu-navigation FSM for the pet UI. It turns the three push-button inputs into clean key events: left/right presses, a short select, and a long-hold back. With these it walks a two-level tree: location, then activity. It drives the location and activity codes consumed by the draw and activity datapaths. It adds cursor wrap-around, back navigation and activity timeout.

## Interface
- NUM_LOCS, 2, number of selectable locations (1..15)
- NUM_ACTS, 2, activities per location (1..15)
- HOLD_CYCLES, 50_000_000, consecutive cycles select must be held alone to issue back (>=2)
- TIMEOUT_CYCLES, 500_000_000, idle cycles in ACTIVE before auto-exit; 0 disables
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- keys  in  3  active-high, already synchronised to clk; [2]=left, [1]=select, [0]=right
- act_done  in  1  single-cycle pulse from the activity datapath ending the activity
- location  out  4  0 = root, else 1..NUM_LOCS
- activity  out  4  0 = none/menu, else 1..NUM_ACTS
- cursor  out  4  highlighted item, 1..N of the current level
- act_start  out  1  one-cycle pulse on entry to ACTIVE
- state  out  2  0 ROOT, 1 MENU, 2 ACTIVE (3 unused, recovers to ROOT)

## Operation
- keys_prev register holds keys sampled on the previous edge. Its reset value is 3'b111, so a key held through reset never fires.
- Left/right event: keys_prev==000 and keys==100 (left) or 001 (right).
- hold_cnt counts consecutive edges with keys==010 and saturates at HOLD_CYCLES.
- hold_cnt clears when keys!=010.
- Back event: on the edge where hold_cnt reaches HOLD_CYCLES. Exactly one back per hold.
- Select event: keys==000, keys_prev==010, hold_cnt<HOLD_CYCLES, no abort.
- Abort flag: set when any other key joins during a select hold (keys not 000/010 while hold_cnt>0). It clears when keys==000. No select fires on that release.
- Any multi-hot press edge generates no event.
- ROOT: left moves cursor to cursor-1 (1 wraps to NUM_LOCS). Right moves it to cursor+1 (NUM_LOCS wraps to 1).
- ROOT select: location<=cursor, cursor<=1, go to MENU. Back is a no-op.
- MENU: left/right move cursor over 1..NUM_ACTS with the same wrap rule.
- MENU select: activity<=cursor, act_start=1 for one cycle, go to ACTIVE.
- MENU back: cursor<=location, location<=0, go to ROOT.
- ACTIVE: left/right/select are ignored for navigation but restart the timeout.
- ACTIVE exits to MENU on act_done, back, or timeout. On exit: cursor<=activity, activity<=0.
- act_done in ROOT/MENU is ignored.
- Simultaneous exit causes produce a single transition.
- If NUM_LOCS or NUM_ACTS is 1, left/right leave cursor at 1.

## Timing
- Reset values: state ROOT, location 0, activity 0, cursor 1, act_start 0, hold_cnt 0, tmo_cnt 0, abort 0, keys_prev 111.
- Reset is asynchronous: asserting resetn low in any state forces all reset values immediately, with no completion of the pending action.
- All outputs are registered. Event detection is combinational on keys/keys_prev; the resulting update is visible after the same edge (latency 1 edge from the sampled key change).
- Select resolves on the release edge. Back resolves on the HOLD_CYCLES-th consecutive sampled edge of the select hold.
- tmo_cnt clears on entry to ACTIVE and on any left/right/select event.
- tmo_cnt increments each ACTIVE cycle. Exit occurs on the edge where it reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the last event.
- act_start is high exactly on the cycle following the entry edge. It is never high in two consecutive cycles.
- Counter widths are $clog2(param+1). No overflow, because hold_cnt saturates and tmo_cnt stops on exit.

## Test plan
Use HOLD_CYCLES=4 and TIMEOUT_CYCLES=10 throughout.
- Reset with keys=010 held, then release: no select.
- Reset with keys=010 held, check outputs: state 0, location 0, cursor 1, activity 0.
- ROOT navigation with NUM_LOCS=3: press/release left once -> cursor 3. Then right twice -> cursor 1, then 2.
- Short select (select held 2 cycles), from the ROOT navigation end state -> location 2, cursor 1, state MENU.
- Select again (held 2 cycles) -> activity 1, act_start pulse 1 cycle, state ACTIVE.
- Long hold in MENU (location 2): hold select 6 cycles -> back on 4th edge, location 0, cursor 2, state ROOT. The release produces no select.
- Chord abort: hold select 2 cycles, add right, release all -> no event, cursor unchanged.
- Timeout in ACTIVE (activity 2): idle -> exit after 10 edges, cursor 2, activity 0.
- Timeout restart: repeat the timeout test with a right press at edge 7 -> exit at edge 17.
- act_done, then async reset: act_done pulse in ACTIVE -> MENU the next edge. Then drop resetn mid-cycle in MENU -> outputs reset before the next clk edge.
